// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_IMM   = 3'd3,
    ST_EXEC  = 3'd4,
    ST_HALT  = 3'd5
  } state_e;

  localparam logic [2:0] OP_MVI    = 3'b001;
  localparam logic [6:0] HALT_MARK = 7'h7F;

  function automatic logic is_mvi(input logic [15:0] word);
    return word[15:13] == OP_MVI;
  endfunction

  function automatic logic is_halt(input logic [15:0] word);
    return word[6:0] == HALT_MARK;
  endfunction

endpackage

// File: rtl/instr_fetch_pc_incr.sv
// Program-counter increment by 1 or 2, wrapping past LAST_ADDR back to 0.
module pc_incr #(
  parameter int ADDR_W    = 5,
  parameter int LAST_ADDR = 2**ADDR_W-1
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [1:0]        step_i,
  output logic [ADDR_W-1:0] nxt_o
);

  // Two guard bits so pc+2 never overflows before the wrap compare.
  localparam logic [ADDR_W+1:0] LAST_EXT = (ADDR_W+2)'(LAST_ADDR);
  localparam logic [ADDR_W+1:0] SPAN     = (ADDR_W+2)'(LAST_ADDR + 1);

  logic [ADDR_W+1:0] sum;

  assign sum   = {2'b00, pc_i} + {{ADDR_W{1'b0}}, step_i};
  assign nxt_o = (sum > LAST_EXT) ? ADDR_W'(sum - SPAN) : ADDR_W'(sum);

endmodule

// File: rtl/instr_fetch.sv
// Fetch sequencer feeding a processor from a synchronous ROM (mvi takes a second word).
// Optional halt-word support is enabled with the FETCH_HALT_EN macro.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int LAST_ADDR = 2**ADDR_W-1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       DIN,
  output logic              Run,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output state_e            state_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_nxt;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       imm_q, imm_d;
  logic              first_q, first_d;
  logic [1:0]        step;

  // Only the pc advance out of EXEC after an mvi skips two words.
  assign step = (state_q == ST_EXEC && is_mvi(instr_q)) ? 2'd2 : 2'd1;

  pc_incr #(
    .ADDR_W   (ADDR_W),
    .LAST_ADDR(LAST_ADDR)
  ) u_pc_incr (
    .pc_i  (pc_q),
    .step_i(step),
    .nxt_o (pc_nxt)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      imm_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    imm_d    = imm_q;
    first_d  = first_q;
    mem_addr = '0;
    DIN      = 16'h0000;
    Run      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_addr = pc_q;
        state_d  = ST_LOAD;
      end
      ST_LOAD: begin
        // Decode straight from the ROM word so the immediate read starts this cycle.
        instr_d = mem_data;
        first_d = 1'b1;
`ifdef FETCH_HALT_EN
        if (is_halt(mem_data)) begin
          state_d = ST_HALT;
        end else if (is_mvi(mem_data)) begin
          mem_addr = pc_nxt;
          state_d  = ST_IMM;
        end else begin
          state_d = ST_EXEC;
        end
`else
        if (is_mvi(mem_data)) begin
          mem_addr = pc_nxt;
          state_d  = ST_IMM;
        end else begin
          state_d = ST_EXEC;
        end
`endif
      end
      ST_IMM: begin
        imm_d   = mem_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        Run     = 1'b1;
        DIN     = (first_q || !is_mvi(instr_q)) ? instr_q : imm_q;
        first_d = 1'b0;
        if (Done) begin
          pc_d    = pc_nxt;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign pc      = pc_q;
  assign state_o = state_q;

`ifdef FETCH_HALT_EN
  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a 5-bit-address instance plus a 2-bit one for wrap checks.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  logic start_a, done_a, start_b, done_b;

  logic [4:0]  addr_a, pc_a;
  logic [15:0] data_a, din_a;
  logic        run_a, busy_a, halted_a;
  state_e      state_a;

  logic [1:0]  addr_b, pc_b;
  logic [15:0] data_b, din_b;
  logic        run_b, busy_b, halted_b;
  state_e      state_b;

  logic [15:0] rom_a [0:31];
  logic [15:0] rom_b [0:3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) data_a <= rom_a[addr_a];
  always @(posedge clk) data_b <= rom_b[addr_b];

  instr_fetch #(.ADDR_W(5)) dut_a (
    .Clock(clk), .Resetn(resetn), .Start(start_a), .Done(done_a),
    .mem_addr(addr_a), .mem_data(data_a), .DIN(din_a), .Run(run_a),
    .busy(busy_a), .halted(halted_a), .pc(pc_a), .state_o(state_a)
  );

  instr_fetch #(.ADDR_W(2)) dut_b (
    .Clock(clk), .Resetn(resetn), .Start(start_b), .Done(done_b),
    .mem_addr(addr_b), .mem_data(data_b), .DIN(din_b), .Run(run_b),
    .busy(busy_b), .halted(halted_b), .pc(pc_b), .state_o(state_b)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic reset_all;
    resetn  = 1'b0;
    start_a = 1'b0; done_a = 1'b0;
    start_b = 1'b0; done_b = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic clear_roms;
    for (int i = 0; i < 32; i++) rom_a[i] = 16'h0000;
    for (int i = 0; i < 4; i++) rom_b[i] = 16'h0000;
  endtask

  task automatic wait_run_a(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (run_a === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_run_b(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (run_b === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    resetn  = 1'b0;
    start_a = 1'b0; done_a = 1'b0;
    start_b = 1'b0; done_b = 1'b0;
    #1;
    n_checks++;
    if ({run_a, din_a, pc_a, addr_a, busy_a, halted_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: run=%b din=%h pc=%0d addr=%0d busy=%b halted=%b, all must be 0",
               run_a, din_a, pc_a, addr_a, busy_a, halted_a);
    end
    n_checks++;
    if (state_a !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d want %0d", state_a, ST_IDLE);
    end
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (state_a !== ST_IDLE || busy_a !== 1'b0 || run_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stay_idle: state=%0d busy=%b run=%b want IDLE,0,0", state_a, busy_a, run_a);
    end
  endtask

  task automatic test_mv;
    clear_roms();
    reset_all();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_checks++;
    if (state_a !== ST_FETCH || addr_a !== 5'd0 || busy_a !== 1'b1 || run_a !== 1'b0) begin
      n_fail++;
      $display("FAIL mv_fetch: state=%0d addr=%0d busy=%b run=%b want FETCH,0,1,0",
               state_a, addr_a, busy_a, run_a);
    end
    tick();
    n_checks++;
    if (state_a !== ST_LOAD || run_a !== 1'b0) begin
      n_fail++; $display("FAIL mv_load: state=%0d run=%b want LOAD,0", state_a, run_a);
    end
    tick();
    n_checks++;
    if (run_a !== 1'b1 || din_a !== 16'h0000 || state_a !== ST_EXEC) begin
      n_fail++;
      $display("FAIL mv_latency3: run=%b din=%h state=%0d want 1,0000,EXEC", run_a, din_a, state_a);
    end
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    n_checks++;
    if (pc_a !== 5'd1 || run_a !== 1'b0 || din_a !== 16'h0000 || state_a !== ST_FETCH) begin
      n_fail++;
      $display("FAIL mv_done: pc=%0d run=%b din=%h state=%0d want 1,0,0000,FETCH",
               pc_a, run_a, din_a, state_a);
    end
  endtask

  task automatic test_mvi;
    clear_roms();
    rom_a[0] = 16'h2000;
    rom_a[1] = 16'h00A5;
    reset_all();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    n_checks++;
    if (state_a !== ST_LOAD || addr_a !== 5'd1) begin
      n_fail++; $display("FAIL mvi_imm_addr: state=%0d addr=%0d want LOAD,1", state_a, addr_a);
    end
    tick();
    n_checks++;
    if (state_a !== ST_IMM || run_a !== 1'b0 || din_a !== 16'h0000) begin
      n_fail++;
      $display("FAIL mvi_imm_state: state=%0d run=%b din=%h want IMM,0,0000", state_a, run_a, din_a);
    end
    tick();
    n_checks++;
    if (run_a !== 1'b1 || din_a !== 16'h2000) begin
      n_fail++; $display("FAIL mvi_first_din: run=%b din=%h want 1,2000", run_a, din_a);
    end
    tick();
    n_checks++;
    if (run_a !== 1'b1 || din_a !== 16'h00A5) begin
      n_fail++; $display("FAIL mvi_second_din: run=%b din=%h want 1,00a5", run_a, din_a);
    end
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    n_checks++;
    if (pc_a !== 5'd2 || run_a !== 1'b0) begin
      n_fail++; $display("FAIL mvi_pc: pc=%0d run=%b want 2,0", pc_a, run_a);
    end
  endtask

  task automatic test_ignore;
    clear_roms();
    rom_a[0] = 16'h0001;
    reset_all();
    start_a = 1'b1;
    done_a  = 1'b1;
    tick();
    tick();
    n_checks++;
    if (state_a !== ST_LOAD || pc_a !== 5'd0 || run_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_load: state=%0d pc=%0d run=%b want LOAD,0,0", state_a, pc_a, run_a);
    end
    tick();
    n_checks++;
    if (run_a !== 1'b1 || din_a !== 16'h0001 || pc_a !== 5'd0) begin
      n_fail++;
      $display("FAIL ignore_exec: run=%b din=%h pc=%0d want 1,0001,0", run_a, din_a, pc_a);
    end
    tick();
    start_a = 1'b0;
    done_a  = 1'b0;
    n_checks++;
    if (state_a !== ST_FETCH || pc_a !== 5'd1 || run_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_next: state=%0d pc=%0d run=%b want FETCH,1,0", state_a, pc_a, run_a);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [15:0] exp_din;
    clear_roms();
    rom_b[0] = 16'h1234;
    rom_b[3] = 16'h2000;
    reset_all();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_run_b(ok);
      exp_din = (i == 0) ? 16'h1234 : 16'h0000;
      n_checks++;
      if (!ok || pc_b !== 2'(i) || din_b !== exp_din) begin
        n_fail++;
        $display("FAIL wrap_step%0d: ok=%b pc=%0d din=%h want 1,%0d,%h", i, ok, pc_b, din_b, i, exp_din);
      end
      done_b = 1'b1;
      tick();
      done_b = 1'b0;
    end
    wait_run_b(ok);
    n_checks++;
    if (!ok || pc_b !== 2'd3 || din_b !== 16'h2000) begin
      n_fail++; $display("FAIL wrap_mvi_first: ok=%b pc=%0d din=%h want 1,3,2000", ok, pc_b, din_b);
    end
    tick();
    n_checks++;
    if (run_b !== 1'b1 || din_b !== 16'h1234) begin
      n_fail++; $display("FAIL wrap_mvi_imm: run=%b din=%h want 1,1234", run_b, din_b);
    end
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    n_checks++;
    if (pc_b !== 2'd1 || run_b !== 1'b0) begin
      n_fail++; $display("FAIL wrap_pc: pc=%0d run=%b want 1,0", pc_b, run_b);
    end
  endtask

  task automatic test_reset_mid_exec;
    bit ok;
    clear_roms();
    rom_a[0] = 16'h0002;
    rom_a[1] = 16'h1111;
    reset_all();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_run_a(ok);
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    wait_run_a(ok);
    n_checks++;
    if (!ok || pc_a !== 5'd1 || din_a !== 16'h1111) begin
      n_fail++; $display("FAIL midrst_pre: ok=%b pc=%0d din=%h want 1,1,1111", ok, pc_a, din_a);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (run_a !== 1'b0 || din_a !== 16'h0000 || pc_a !== 5'd0 || state_a !== ST_IDLE ||
        busy_a !== 1'b0 || addr_a !== 5'd0) begin
      n_fail++;
      $display("FAIL midrst_async: run=%b din=%h pc=%0d state=%0d busy=%b addr=%0d want 0,0000,0,IDLE,0,0",
               run_a, din_a, pc_a, state_a, busy_a, addr_a);
    end
    tick();
    resetn = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (state_a !== ST_IDLE) begin
      n_fail++; $display("FAIL midrst_idle: state=%0d want IDLE", state_a);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_checks++;
    if (state_a !== ST_FETCH || addr_a !== 5'd0) begin
      n_fail++; $display("FAIL midrst_refetch: state=%0d addr=%0d want FETCH,0", state_a, addr_a);
    end
    repeat (2) tick();
    n_checks++;
    if (run_a !== 1'b1 || din_a !== 16'h0002) begin
      n_fail++; $display("FAIL midrst_rerun: run=%b din=%h want 1,0002", run_a, din_a);
    end
  endtask

  task automatic test_halt;
    bit ok;
    bit run_seen;
    clear_roms();
    rom_a[2] = 16'h007F;
    reset_all();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_run_a(ok);
      n_checks++;
      if (!ok || pc_a !== 5'(i)) begin
        n_fail++; $display("FAIL halt_pre%0d: ok=%b pc=%0d want 1,%0d", i, ok, pc_a, i);
      end
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
    end
    tick();
    run_seen = run_a;
    tick();
`ifdef FETCH_HALT_EN
    n_checks++;
    if (halted_a !== 1'b1 || busy_a !== 1'b0 || run_a !== 1'b0 || run_seen || pc_a !== 5'd2) begin
      n_fail++;
      $display("FAIL halt_enter: halted=%b busy=%b run=%b seen=%b pc=%0d want 1,0,0,0,2",
               halted_a, busy_a, run_a, run_seen, pc_a);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (3) begin
      tick();
      if (run_a !== 1'b0) run_seen = 1'b1;
    end
    n_checks++;
    if (halted_a !== 1'b1 || run_seen || pc_a !== 5'd2 || state_a !== ST_HALT) begin
      n_fail++;
      $display("FAIL halt_stuck: halted=%b seen=%b pc=%0d state=%0d want 1,0,2,HALT",
               halted_a, run_seen, pc_a, state_a);
    end
`else
    n_checks++;
    if (run_a !== 1'b1 || din_a !== 16'h007F || halted_a !== 1'b0 || run_seen) begin
      n_fail++;
      $display("FAIL halt_as_mv: run=%b din=%h halted=%b seen=%b want 1,007f,0,0",
               run_a, din_a, halted_a, run_seen);
    end
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    n_checks++;
    if (pc_a !== 5'd3 || halted_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_as_mv_pc: pc=%0d halted=%b busy=%b want 3,0,1", pc_a, halted_a, busy_a);
    end
`endif
  endtask

  initial begin
    clear_roms();
    test_reset();
    test_mv();
    test_mvi();
    test_ignore();
    test_wrap();
    test_reset_mid_exec();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 5, instruction-memory address width.
REQ-002 Parameter LAST_ADDR, default 2**ADDR_W-1, highest program address; the PC wraps from it to 0.
REQ-003 Clock  input  1  system clock; all state changes on the rising edge.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  begins fetching at the current PC when the block is idle.
REQ-006 Done  input  1  processor completion flag, sampled on the rising edge.
REQ-007 mem_addr  output  ADDR_W  synchronous-ROM read address.
REQ-008 mem_data  input  16  ROM read data, valid one cycle after mem_addr.
REQ-009 DIN  output  16  word presented to the processor.
REQ-010 Run  output  1  processor execute enable.
REQ-011 busy  output  1  high in every state except IDLE and HALT.
REQ-012 halted  output  1  high in HALT.
REQ-013 pc  output  ADDR_W  address of the instruction now in flight.

Function
REQ-014 The block SHALL implement states IDLE, FETCH, LOAD, IMM, EXEC and HALT.
REQ-015 IDLE: Run=0; Start=1 SHALL go to FETCH.
REQ-016 FETCH: mem_addr=pc; next state SHALL be LOAD.
REQ-017 LOAD: the block SHALL capture mem_data into instr_q.
- If instr_q[15:13]==3'b001 (mvi): drive mem_addr=pc+1 (wrapped) and go to IMM.
- Otherwise: go to EXEC.
REQ-018 IMM: the block SHALL capture mem_data into imm_q, then go to EXEC.
REQ-019 EXEC: Run=1; DIN=instr_q in the first EXEC cycle and imm_q in later cycles for mvi, instr_q otherwise.
REQ-020 EXEC SHALL hold Run high until Done is sampled high; Run SHALL be 0 in the following cycle.
REQ-021 On Done the block SHALL advance pc by 1 (by 2 for mvi), wrapping past LAST_ADDR to 0, and return to FETCH.
REQ-022 Outside EXEC, DIN SHALL be 16'h0000 and Run SHALL be 0.
REQ-023 Start SHALL be ignored outside IDLE; Done SHALL be ignored outside EXEC.
REQ-024 The mvi immediate fetched at LAST_ADDR SHALL come from address 0.
REQ-025 Latency from Start to the first Run SHALL be 3 cycles for a non-mvi instruction and 4 cycles for mvi.

Reset
REQ-026 Resetn=0 SHALL immediately force IDLE with pc=0, instr_q=0, imm_q=0, Run=0, DIN=0, busy=0, halted=0, mem_addr=0, including mid-EXEC.
REQ-027 After reset the block SHALL stay in IDLE until Start.

Configuration
REQ-028 Macro FETCH_HALT_EN SHALL control halt support.
- Defined: a LOAD word with bits [6:0]==7'h7F SHALL enter HALT instead of EXEC, with no Run and pc unchanged; only reset leaves HALT.
- Undefined: bits [6:0] SHALL be ignored, HALT is unreachable, and halted is tied to 0.

Structure
REQ-029 A shared package SHALL hold the state enum, the opcode constant OP_MVI=3'b001, and HALT_MARK=7'h7F.
REQ-030 The PC wrap-increment SHALL be one sub-module, pc_incr (inputs pc and step 1/2, LAST_ADDR parameter); the rest is a single FSM module.

Verification
REQ-031 ROM[0]=16'h0000 (mv); Start pulse -> Run rises 3 cycles later with DIN=16'h0000; Done after 1 cycle -> pc=1 and Run=0 the next cycle.
REQ-032 ROM[0]=16'h2000 (mvi R0), ROM[1]=16'h00A5 -> DIN=16'h2000 in the first Run cycle and 16'h00A5 in the second; on Done pc=2.
REQ-033 ADDR_W=2, ROM[3] mvi, ROM[0]=immediate 16'h1234 -> DIN shows 16'h1234 in the second Run cycle; on Done pc wraps to 1.
REQ-034 Resetn pulsed low mid-EXEC -> Run and DIN drop without waiting for a clock, pc=0, IDLE; a later Start refetches from 0.
REQ-035 With FETCH_HALT_EN, ROM[2]=16'h007F -> after two instructions halted=1 with Run never asserted, and Start is ignored; without the macro the same word executes as mv.
